// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: FSM states,
// header layout, buffer geometry and small helper functions.
package router_pkg;

  // Transmitter FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_HDR     = 3'd2,
    ST_SRC     = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_PARITY  = 3'd5
  } tx_state_t;

  // Destination code that no router port answers to.
  localparam logic [1:0] DEST_INVALID = 2'b11;

  // Largest payload a packet can carry; the buffer holds one full packet.
  localparam int MAX_LEN   = 63;
  localparam int BUF_DEPTH = MAX_LEN + 1;
  localparam int BUF_AW    = 6;

  // Header byte field positions: {len[5:0], dest[1:0]}.
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_DEST_MSB = 1;
  localparam int HDR_DEST_LSB = 0;

  // Assemble the header byte from the latched length and destination.
  function automatic logic [7:0] build_header(input logic [5:0] len,
                                              input logic [1:0] dest);
    logic [7:0] hdr;
    hdr = 8'h00;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    hdr[HDR_DEST_MSB:HDR_DEST_LSB] = dest;
    return hdr;
  endfunction

  // A request is legal when it names a real port and carries payload.
  function automatic logic request_legal(input logic [1:0] dest,
                                         input logic [5:0] len);
    return (dest != DEST_INVALID) && (len != 6'd0);
  endfunction

  // Fold one byte into a running XOR parity.
  function automatic logic [7:0] parity_fold(input logic [7:0] acc,
                                             input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/tx_payload_buf.sv
// Payload store for one packet: 64x8, synchronous write, registered read.
// The read port is free-running so the transmitter can keep the next
// payload byte prefetched while the current one sits on the output.
module tx_payload_buf
  import router_pkg::*;
(
  input  logic              clk1,
  input  logic              i_we,
  input  logic [BUF_AW-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [BUF_AW-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [0:BUF_DEPTH-1];

  // Write port: store a payload byte as the host hands it over.
  always_ff @(posedge clk1) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: register the addressed byte every cycle.
  always_ff @(posedge clk1) begin
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter. Accepts a packet request, buffers the host's
// payload, then streams header, source ID, payload and XOR parity to the
// router as one contiguous valid burst, honouring router back-pressure.
module router_pkt_tx
  import router_pkg::*;
(
  input  logic       clk1,
  input  logic       reset,
  input  logic       start_i,
  input  logic [1:0] dest_i,
  input  logic [7:0] src_id_i,
  input  logic [5:0] len_i,
  input  logic [7:0] pl_data_i,
  input  logic       pl_valid_i,
  output logic       pl_ready_o,
  input  logic       stop_packet_send,
  output logic [7:0] packet_out,
  output logic       packet_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  tx_state_t         r_state;
  logic [1:0]        r_dest;
  logic [7:0]        r_src;
  logic [5:0]        r_len;
  logic [BUF_AW-1:0] r_wr_ptr;
  logic [BUF_AW-1:0] r_rd_ptr;
  logic [7:0]        r_parity;
  logic [7:0]        r_packet_out;
  logic              r_valid;
  logic              r_pl_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_pl_xfer;
  logic              w_tx_xfer;
  logic              w_consume;
  logic              w_last_pl;
  logic [BUF_AW-1:0] w_rd_addr;
  logic [7:0]        w_rd_data;

  // Host hands over a payload byte.
  assign w_pl_xfer = pl_valid_i && r_pl_ready;
  // The byte on packet_out is taken by the router this cycle.
  assign w_tx_xfer = r_valid && !stop_packet_send;
  // r_rd_ptr counts payload bytes already moved to packet_out; once it
  // reaches r_len the next thing to send is the parity byte.
  assign w_last_pl = (r_rd_ptr == r_len);
  // A buffered payload byte moves onto packet_out at this edge.
  assign w_consume = w_tx_xfer &&
                     ((r_state == ST_SRC) ||
                      ((r_state == ST_PAYLOAD) && !w_last_pl));

  // Prefetch address: the buffer output always shows the byte that will
  // be sent next, so advance the read address when a byte is consumed.
  always_comb begin
    w_rd_addr = r_rd_ptr;
    if (w_consume) begin
      w_rd_addr = r_rd_ptr + 6'd1;
    end else begin
      w_rd_addr = r_rd_ptr;
    end
  end

  tx_payload_buf u_buf (
    .clk1    (clk1),
    .i_we    (w_pl_xfer),
    .i_waddr (r_wr_ptr),
    .i_wdata (pl_data_i),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // Transmit FSM with all outputs registered.
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_dest       <= 2'b00;
      r_src        <= 8'h00;
      r_len        <= 6'd0;
      r_wr_ptr     <= 6'd0;
      r_rd_ptr     <= 6'd0;
      r_parity     <= 8'h00;
      r_packet_out <= 8'h00;
      r_valid      <= 1'b0;
      r_pl_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_parity <= 8'h00;
          r_wr_ptr <= 6'd0;
          r_rd_ptr <= 6'd0;
          // The done_o cycle still reads as idle; a request there is not
          // taken so back-to-back packets never touch.
          if (start_i && !r_done) begin
            if (request_legal(dest_i, len_i)) begin
              r_dest     <= dest_i;
              r_src      <= src_id_i;
              r_len      <= len_i;
              r_pl_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= ST_LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (w_pl_xfer) begin
            r_wr_ptr <= r_wr_ptr + 6'd1;
            if (r_wr_ptr == (r_len - 6'd1)) begin
              r_pl_ready   <= 1'b0;
              r_packet_out <= build_header(r_len, r_dest);
              r_valid      <= 1'b1;
              r_state      <= ST_HDR;
            end
          end
        end

        ST_HDR: begin
          if (w_tx_xfer) begin
            r_parity     <= parity_fold(r_parity, r_packet_out);
            r_packet_out <= r_src;
            r_state      <= ST_SRC;
          end
        end

        ST_SRC: begin
          if (w_tx_xfer) begin
            r_parity     <= parity_fold(r_parity, r_packet_out);
            r_packet_out <= w_rd_data;
            r_rd_ptr     <= r_rd_ptr + 6'd1;
            r_state      <= ST_PAYLOAD;
          end
        end

        ST_PAYLOAD: begin
          if (w_tx_xfer) begin
            r_parity <= parity_fold(r_parity, r_packet_out);
            if (w_last_pl) begin
              // Final payload byte leaves now; parity covers it too.
              r_packet_out <= parity_fold(r_parity, r_packet_out);
              r_state      <= ST_PARITY;
            end else begin
              r_packet_out <= w_rd_data;
              r_rd_ptr     <= r_rd_ptr + 6'd1;
            end
          end
        end

        ST_PARITY: begin
          if (w_tx_xfer) begin
            r_packet_out <= 8'h00;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end

        default: begin
          r_packet_out <= 8'h00;
          r_valid      <= 1'b0;
          r_pl_ready   <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign pl_ready_o     = r_pl_ready;
  assign packet_out     = r_packet_out;
  assign packet_valid_o = r_valid;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign err_o          = r_err;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx. Expected byte streams come from a
// queue-based packet model built from the packet format rules.
module tb_router_pkt_tx;

  logic       clk1 = 1'b0;
  logic       reset;
  logic       start_i;
  logic [1:0] dest_i;
  logic [7:0] src_id_i;
  logic [5:0] len_i;
  logic [7:0] pl_data_i;
  logic       pl_valid_i;
  logic       pl_ready_o;
  logic       stop_packet_send;
  logic [7:0] packet_out;
  logic       packet_valid_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] pay[$];
  logic [7:0] exp_q[$];

  router_pkt_tx dut (
    .clk1             (clk1),
    .reset            (reset),
    .start_i          (start_i),
    .dest_i           (dest_i),
    .src_id_i         (src_id_i),
    .len_i            (len_i),
    .pl_data_i        (pl_data_i),
    .pl_valid_i       (pl_valid_i),
    .pl_ready_o       (pl_ready_o),
    .stop_packet_send (stop_packet_send),
    .packet_out       (packet_out),
    .packet_valid_o   (packet_valid_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o)
  );

  always #5 clk1 = ~clk1;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference packet: header, source, payload, then XOR of everything before.
  task automatic build_expected(input logic [1:0] d, input logic [7:0] s, input logic [5:0] l);
    logic [7:0] par;
    exp_q = {};
    exp_q.push_back({l, d});
    exp_q.push_back(s);
    foreach (pay[i]) exp_q.push_back(pay[i]);
    par = 8'h00;
    foreach (exp_q[i]) par = par ^ exp_q[i];
    exp_q.push_back(par);
  endtask

  task automatic fill_random(input int l);
    pay = {};
    for (int i = 0; i < l; i++) pay.push_back(8'($urandom));
  endtask

  task automatic start_pkt(input logic [1:0] d, input logic [7:0] s, input logic [5:0] l,
                           input bit hold, input int exp_lat);
    int lat;
    lat = 0;
    dest_i = d; src_id_i = s; len_i = l; start_i = 1'b1;
    do begin
      tick();
      lat++;
    end while (!busy_o && lat < 5);
    if (!hold) start_i = 1'b0;
    check("start_busy", busy_o, 32'd1);
    if (exp_lat > 0) check("start_latency", lat, exp_lat);
    check("load_ready", pl_ready_o, 32'd1);
    check("load_no_valid", packet_valid_o, 32'd0);
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random valid.
  task automatic load_payload(input int mode);
    int idx, guard;
    bit v, rdy;
    idx = 0; guard = 0;
    while (idx < pay.size() && guard < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      pl_valid_i = v;
      pl_data_i  = v ? pay[idx] : 8'($urandom);
      rdy = pl_ready_o;
      tick();
      if (v && rdy) idx++;
      guard++;
    end
    pl_valid_i = 1'b0;
    check("load_count", idx, pay.size());
    check("load_ready_drop", pl_ready_o, 32'd0);
  endtask

  // smode 0: no stall, 1: stall slen cycles on byte sidx, 2: random stalls.
  task automatic stream_out(input int smode, input int sidx, input int slen);
    int got, held, bubbles, guard;
    bit stop, err_seen;
    got = 0; held = 0; bubbles = 0; guard = 0; err_seen = 1'b0;
    while (got < exp_q.size() && guard < 2000) begin
      case (smode)
        0:       stop = 1'b0;
        1:       stop = (got == sidx) && (held < slen);
        default: stop = ($urandom_range(0, 3) == 0);
      endcase
      stop_packet_send = stop;
      err_seen |= err_o;
      if (!packet_valid_o) begin
        bubbles++;
      end else if (stop) begin
        held++;
        check($sformatf("hold_byte%0d", got), packet_out, exp_q[got]);
      end else begin
        check($sformatf("byte%0d", got), packet_out, exp_q[got]);
        got++;
      end
      tick();
      guard++;
    end
    stop_packet_send = 1'b0;
    check("stream_len", got, exp_q.size());
    check("bubbles", bubbles, 32'd0);
    check("no_err_while_busy", err_seen, 32'd0);
    if (smode == 1) check("stall_cycles", held, slen);
    check("done_pulse", done_o, 32'd1);
    check("end_valid_low", packet_valid_o, 32'd0);
    check("end_idle", busy_o, 32'd0);
    tick();
    check("done_one_cycle", done_o, 32'd0);
    check("after_done_valid_low", packet_valid_o, 32'd0);
  endtask

  task automatic run_pkt(input logic [1:0] d, input logic [7:0] s, input int lmode,
                         input int smode, input int sidx, input int slen);
    build_expected(d, s, 6'(pay.size()));
    start_pkt(d, s, 6'(pay.size()), 1'b0, 1);
    load_payload(lmode);
    stream_out(smode, sidx, slen);
  endtask

  task automatic reject(input logic [1:0] d, input logic [5:0] l, input string tag);
    dest_i = d; len_i = l; src_id_i = 8'h5A; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check({tag, "_err"}, err_o, 32'd1);
    check({tag, "_valid"}, packet_valid_o, 32'd0);
    check({tag, "_busy"}, busy_o, 32'd0);
    tick();
    check({tag, "_err_pulse"}, err_o, 32'd0);
    check({tag, "_stay_idle"}, busy_o, 32'd0);
    check({tag, "_valid2"}, packet_valid_o, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; dest_i = 2'd0; src_id_i = 8'h00; len_i = 6'd0;
    pl_data_i = 8'h00; pl_valid_i = 1'b0; stop_packet_send = 1'b0;
    tick(); tick();
    check("rst_packet_out", packet_out, 32'h00);
    check("rst_valid", packet_valid_o, 32'd0);
    check("rst_ready", pl_ready_o, 32'd0);
    check("rst_busy", busy_o, 32'd0);
    check("rst_done", done_o, 32'd0);
    check("rst_err", err_o, 32'd0);
    reset = 1'b0;
    tick();

    // Basic two-byte packet, no stall.
    pay = {8'hF0, 8'h0F};
    run_pkt(2'd1, 8'h9F, 0, 0, 0, 0);

    // Rejected requests.
    reject(2'd3, 6'd5, "dest3");
    reject(2'd0, 6'd0, "len0");

    // Same packet with the source byte held for three stall cycles.
    pay = {8'hF0, 8'h0F};
    run_pkt(2'd1, 8'h9F, 0, 1, 1, 3);

    // Maximum length, host valid every other cycle.
    fill_random(63);
    run_pkt(2'd2, 8'h81, 1, 0, 0, 0);

    // Minimum length with a stall on the parity byte.
    fill_random(1);
    run_pkt(2'd0, 8'h7E, 0, 1, 3, 2);

    // Reset in the middle of the payload.
    fill_random(10);
    build_expected(2'd2, 8'h33, 6'd10);
    start_pkt(2'd2, 8'h33, 6'd10, 1'b0, 1);
    load_payload(0);
    tick(); tick(); tick(); tick();
    check("pre_reset_valid", packet_valid_o, 32'd1);
    reset = 1'b1;
    tick();
    check("abort_valid", packet_valid_o, 32'd0);
    check("abort_busy", busy_o, 32'd0);
    check("abort_out", packet_out, 32'h00);
    check("abort_done", done_o, 32'd0);
    reset = 1'b0;
    tick();
    fill_random(5);
    run_pkt(2'd0, 8'hC4, 2, 0, 0, 0);

    // start_i held high across two packets.
    fill_random(4);
    build_expected(2'd1, 8'h12, 6'd4);
    start_pkt(2'd1, 8'h12, 6'd4, 1'b1, 1);
    load_payload(0);
    stream_out(0, 0, 0);
    start_pkt(2'd1, 8'h12, 6'd4, 1'b1, 0);
    start_i = 1'b0;
    load_payload(0);
    stream_out(0, 0, 0);
    tick();
    check("held_start_released", busy_o, 32'd0);

    // Randomised packets with random host and router behaviour.
    for (int n = 0; n < 8; n++) begin
      fill_random($urandom_range(1, 63));
      run_pkt(2'($urandom_range(0, 2)), 8'($urandom), 2, 2, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
